// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: jump redirect, instruction-memory port and the
// valid/ready channel towards decode. The master side is the fetch unit.
interface fetch_pc_unit_if #(
  parameter int unsigned PC_WIDTH = 32
);
  // Redirect from jump_controller
  logic                jump_flag;
  logic [PC_WIDTH-1:0] jump_target;
  // Instruction-memory request / response
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_resp_valid;
  logic [31:0]         imem_resp_data;
  // Decode channel
  logic                if_valid;
  logic                if_ready;
  logic [PC_WIDTH-1:0] if_pc;
  logic [31:0]         if_inst;
  logic [PC_WIDTH-1:0] if_default_target;

  modport master (
    input  jump_flag, jump_target,
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output if_valid, if_pc, if_inst, if_default_target,
    input  if_ready
  );

  modport slave (
    output jump_flag, jump_target,
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  if_valid, if_pc, if_inst, if_default_target,
    output if_ready
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch stage.
// One request in flight at a time; a redirect that overtakes an in-flight
// request marks its response for discard so decode never sees a stale word.
module fetch_pc_unit #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input logic             clk,
  input logic             rst_n,
  fetch_pc_unit_if.master bus
);

  localparam int unsigned INST_W = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic                r_drop;
  logic                w_drop_nxt;
  logic [INST_W-1:0]   r_inst_buf;
  logic [INST_W-1:0]   w_inst_buf_nxt;

  logic [PC_WIDTH-1:0] w_target;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic                w_req_valid;
  logic                w_if_valid;
  logic [1:0]          w_unused_tgt_lo;

  // Redirects are word aligned; the low target bits carry no meaning here.
  assign w_target        = {bus.jump_target[PC_WIDTH-1:2], 2'b00};
  assign w_unused_tgt_lo = bus.jump_target[1:0];
  assign w_pc_inc        = r_pc + PC_WIDTH'(4);

  // State, PC, discard flag and instruction buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_VECTOR;
      r_drop     <= 1'b0;
      r_inst_buf <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_inst_buf <= w_inst_buf_nxt;
    end
  end

  // Next-state, PC update and handshake outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drop_nxt     = r_drop;
    w_inst_buf_nxt = r_inst_buf;
    w_req_valid    = 1'b0;
    w_if_valid     = 1'b0;

    case (r_state)
      S_REQ: begin
        w_req_valid = 1'b1;
        if (bus.jump_flag) begin
          w_pc_nxt = w_target;
        end
        if (bus.imem_req_ready) begin
          // A jump in the accept cycle means the request just issued is
          // already for the old path.
          w_state_nxt = S_WAIT;
          w_drop_nxt  = bus.jump_flag;
        end
      end

      S_WAIT: begin
        if (bus.jump_flag) begin
          w_pc_nxt   = w_target;
          w_drop_nxt = 1'b1;
        end
        if (bus.imem_resp_valid) begin
          if (r_drop || bus.jump_flag) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_inst_buf_nxt = bus.imem_resp_data;
            w_state_nxt    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // A jump squashes the buffered (younger) instruction.
        w_if_valid = !bus.jump_flag;
        if (bus.jump_flag) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (bus.if_ready) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  assign bus.imem_req_valid    = w_req_valid;
  assign bus.imem_addr         = r_pc;
  assign bus.if_valid          = w_if_valid;
  assign bus.if_pc             = r_pc;
  assign bus.if_inst           = r_inst_buf;
  assign bus.if_default_target = w_pc_inc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: transaction-level model of the fetch stage,
// variable-latency memory, directed scenarios then randomized traffic.
module tb_fetch_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.PC_WIDTH(32)) bus ();

  fetch_pc_unit #(.PC_WIDTH(32), .RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;

  // Architectural model: PC plus where the current fetch stands.
  logic [31:0] m_pc;
  bit          m_out;    // request accepted, response not yet back
  bit          m_stale;  // in-flight response belongs to an abandoned path
  bit          m_hold;   // instruction buffered for decode
  logic [31:0] m_held;
  logic        m_req;
  assign m_req = !m_out && !m_hold;

  logic [31:0] m_pc_n, tgt;
  bit          exp_req, exp_ifv;

  // Observed transactions
  bit          hs_flag = 1'b0;
  logic [31:0] hs_addr;
  logic [31:0] hs_addr_q[$];
  int          hs_cyc_q[$];
  logic [31:0] pres_pc_q[$];
  logic [31:0] pres_inst_q[$];
  int          pres_cyc_q[$];

  // Memory: pending responses with their due cycle
  int          due_q[$];
  logic [31:0] dat_q[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    hs_addr_q.delete();
    hs_cyc_q.delete();
    pres_pc_q.delete();
    pres_inst_q.delete();
    pres_cyc_q.delete();
  endtask

  // Advance one cycle and let the memory answer anything due now.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (hs_flag) begin
      due_q.push_back(cyc + lat - 1);
      dat_q.push_back(mem_fn(hs_addr));
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
  endtask

  // Compare against the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_if_inst", bus.if_inst, 32'd0);
      chk("rst_imem_addr", bus.imem_addr, RV);
      chk("rst_if_pc", bus.if_pc, RV);
      m_pc    = RV;
      m_out   = 1'b0;
      m_stale = 1'b0;
      m_hold  = 1'b0;
      m_held  = '0;
      hs_flag = 1'b0;
    end else begin
      exp_req = !m_out && !m_hold;
      exp_ifv = m_hold && !bus.jump_flag;
      chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("if_pc", bus.if_pc, m_pc);
      chk("default_target", bus.if_default_target, m_pc + 32'd4);
      chk("if_valid", 32'(bus.if_valid), 32'(exp_ifv));
      if (m_hold) begin
        chk("if_inst_held", bus.if_inst, m_held);
        chk("if_inst_vs_mem", bus.if_inst, mem_fn(m_pc));
      end

      hs_flag = bus.imem_req_valid && bus.imem_req_ready;
      hs_addr = bus.imem_addr;
      if (hs_flag) begin
        hs_addr_q.push_back(bus.imem_addr);
        hs_cyc_q.push_back(cyc);
      end
      if (bus.if_valid && bus.if_ready) begin
        pres_pc_q.push_back(bus.if_pc);
        pres_inst_q.push_back(bus.if_inst);
        pres_cyc_q.push_back(cyc);
      end

      tgt = {bus.jump_target[31:2], 2'b00};
      if (bus.jump_flag)                m_pc_n = tgt;
      else if (exp_ifv && bus.if_ready) m_pc_n = m_pc + 32'd4;
      else                              m_pc_n = m_pc;

      if (m_hold) begin
        if (bus.jump_flag || bus.if_ready) m_hold = 1'b0;
      end else if (!m_out) begin
        if (bus.imem_req_ready) begin
          m_out   = 1'b1;
          m_stale = bus.jump_flag;
        end
      end else if (bus.imem_resp_valid) begin
        m_out = 1'b0;
        if (!(m_stale || bus.jump_flag)) begin
          m_hold = 1'b1;
          m_held = bus.imem_resp_data;
        end
        m_stale = 1'b0;
      end else if (bus.jump_flag) begin
        m_stale = 1'b1;
      end
      m_pc = m_pc_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_exp;
    rst_n               = 1'b0;
    bus.jump_flag       = 1'b0;
    bus.jump_target     = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.if_ready        = 1'b0;
    repeat (3) tick();

    // 1: streaming fetch after reset, zero-wait memory
    clear_logs();
    lat = 1;
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    #1;
    chk("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t1_addr", bus.imem_addr, RV);
    chk("t1_if_valid", 32'(bus.if_valid), 32'd0);
    repeat (10) tick();
    chk("t1_nreq", 32'(hs_addr_q.size() >= 3 && pres_pc_q.size() >= 3), 32'd1);
    if (hs_addr_q.size() >= 3 && pres_pc_q.size() >= 3) begin
      chk("t1_addr0", hs_addr_q[0], 32'h0);
      chk("t1_addr1", hs_addr_q[1], 32'h4);
      chk("t1_addr2", hs_addr_q[2], 32'h8);
      chk("t1_pc2", pres_pc_q[2], 32'h8);
      chk("t1_inst1", pres_inst_q[1], mem_fn(32'h4));
      chk("t1_latency", 32'(pres_cyc_q[0] - hs_cyc_q[0]), 32'd2);
      chk("t1_period", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd3);
    end

    // 2: memory not ready for 5 cycles
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 10 && !m_req; i++) tick();
    chk("t2_reach", 32'(m_req), 32'd1);
    a_exp = m_pc;
    clear_logs();
    repeat (5) tick();
    chk("t2_no_req", 32'(hs_addr_q.size()), 32'd0);
    chk("t2_no_valid", 32'(pres_pc_q.size()), 32'd0);
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 5 && hs_addr_q.size() == 0; i++) tick();
    chk("t2_resumed", 32'(hs_addr_q.size() > 0), 32'd1);
    if (hs_addr_q.size() > 0) chk("t2_addr", hs_addr_q[0], a_exp);

    // 3: redirect while the response is still in flight
    lat = 2;
    for (int i = 0; i < 10 && !(m_out && !m_stale); i++) tick();
    chk("t3_reach", 32'(m_out), 32'd1);
    clear_logs();
    bus.jump_flag = 1'b1;
    bus.jump_target = 32'h100;
    tick();
    bus.jump_flag = 1'b0;
    for (int i = 0; i < 20 && pres_pc_q.size() == 0; i++) tick();
    chk("t3_seen", 32'(hs_addr_q.size() > 0 && pres_pc_q.size() > 0), 32'd1);
    if (hs_addr_q.size() > 0 && pres_pc_q.size() > 0) begin
      chk("t3_addr", hs_addr_q[0], 32'h100);
      chk("t3_pc", pres_pc_q[0], 32'h100);
      chk("t3_inst", pres_inst_q[0], mem_fn(32'h100));
    end

    // 4: jump squashes a held instruction even with decode ready
    lat = 1;
    bus.if_ready = 1'b0;
    for (int i = 0; i < 10 && !m_hold; i++) tick();
    chk("t4_reach", 32'(m_hold), 32'd1);
    clear_logs();
    bus.if_ready = 1'b1;
    bus.jump_flag = 1'b1;
    bus.jump_target = 32'h203;
    #1;
    chk("t4_if_valid", 32'(bus.if_valid), 32'd0);
    tick();
    bus.jump_flag = 1'b0;
    for (int i = 0; i < 10 && hs_addr_q.size() == 0; i++) tick();
    chk("t4_req", 32'(hs_addr_q.size() > 0), 32'd1);
    if (hs_addr_q.size() > 0) chk("t4_addr", hs_addr_q[0], 32'h200);

    // 5: PC wraps from the top of the address space
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 10 && !m_req; i++) tick();
    bus.jump_flag = 1'b1;
    bus.jump_target = 32'hFFFF_FFFF;
    tick();
    bus.jump_flag = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b0;
    for (int i = 0; i < 10 && !m_hold; i++) tick();
    chk("t5_reach", 32'(m_hold), 32'd1);
    #1;
    chk("t5_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("t5_default", bus.if_default_target, 32'h0);
    chk("t5_if_valid", 32'(bus.if_valid), 32'd1);
    clear_logs();
    bus.if_ready = 1'b1;
    for (int i = 0; i < 10 && hs_addr_q.size() == 0; i++) tick();
    chk("t5_req", 32'(hs_addr_q.size() > 0), 32'd1);
    if (hs_addr_q.size() > 0) chk("t5_addr", hs_addr_q[0], 32'h0);

    // 6: reset while waiting; the old response lands after release
    for (int i = 0; i < 10 && !m_req; i++) tick();
    lat = 4;
    for (int i = 0; i < 10 && !m_out; i++) tick();
    chk("t6_reach", 32'(m_out), 32'd1);
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10 && due_q.size() > 0; i++) tick();
    chk("t6_stale_done", 32'(due_q.size()), 32'd0);
    clear_logs();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 10 && pres_pc_q.size() == 0; i++) tick();
    chk("t6_seen", 32'(hs_addr_q.size() > 0 && pres_pc_q.size() > 0), 32'd1);
    if (hs_addr_q.size() > 0 && pres_pc_q.size() > 0) begin
      chk("t6_addr", hs_addr_q[0], RV);
      chk("t6_pc", pres_pc_q[0], RV);
      chk("t6_inst", pres_inst_q[0], mem_fn(RV));
    end

    // Randomized traffic
    clear_logs();
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.imem_req_ready = ($urandom_range(0, 9) < 7);
      bus.if_ready       = ($urandom_range(0, 9) < 6);
      bus.jump_flag      = ($urandom_range(0, 15) == 0);
      bus.jump_target    = $urandom;
      if ($urandom_range(0, 7) == 0) bus.jump_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      lat = $urandom_range(1, 3);
    end
    bus.jump_flag = 1'b0;
    tick();
    chk("rand_progress", 32'(pres_pc_q.size() > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
